trig_clk_ps_seq: RTL and testbench

Multi-step phase-shift sequencer for the trigger-clock MMCM, in the `cwusb_clk` domain between the main register block and the MMCM dynamic phase-shift port. One register command requests a signed number of fine-phase steps. The block then issues one `psen` pulse per step, waits for `psdone` before the next, tracks the accumulated phase position, and reports completion, errors and timeouts.

---
 rtl/trig_clk_ps_seq_pkg.sv | 20 ++
 rtl/trig_clk_ps_seq.sv | 145 ++++++++++++++
 tb/tb_trig_clk_ps_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_clk_ps_seq_pkg.sv
// Shared definitions for the trigger-clock MMCM phase-shift sequencer and
// the register block that drives it.
package trig_clk_ps_seq_pkg;

    // REG_PS_CTRL bit positions
    localparam int PS_CTRL_START_BIT     = 0;
    localparam int PS_CTRL_ABORT_BIT     = 1;
    localparam int PS_CTRL_CLEAR_POS_BIT = 2;

    // REG_PS_STATUS bit positions
    localparam int PS_STATUS_BUSY_BIT    = 0;
    localparam int PS_STATUS_ERROR_BIT   = 1;
    localparam int PS_STATUS_TIMEOUT_BIT = 2;

    typedef enum logic {
        PS_DEC = 1'b0,
        PS_INC = 1'b1
    } ps_dir_e;

endpackage

// File: rtl/trig_clk_ps_seq.sv
// Multi-step MMCM fine phase-shift sequencer: one command issues |I_steps|
// psen/psdone round trips and tracks the accumulated phase position.
module trig_clk_ps_seq
    import trig_clk_ps_seq_pkg::*;
#(
    parameter int pSTEP_WIDTH     = 16,
    parameter int pPOS_WIDTH      = 16,
    parameter int pTIMEOUT_CYCLES = 1023
) (
    input  logic                   cwusb_clk,
    input  logic                   reset_i,
    input  logic                   I_start,
    input  logic [pSTEP_WIDTH-1:0] I_steps,
    input  logic                   I_abort,
    input  logic                   I_clear_pos,
    input  logic                   I_locked,
    input  logic                   I_psdone,
    output logic                   O_psen,
    output logic                   O_psincdec,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_error,
    output logic                   O_timeout,
    output logic [pSTEP_WIDTH-1:0] O_remaining,
    output logic [pPOS_WIDTH-1:0]  O_position
);

    localparam int CNT_W = $clog2(pTIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(pTIMEOUT_CYCLES - 1);
    localparam logic [pSTEP_WIDTH-1:0] STEP_ONE     = pSTEP_WIDTH'(1);
    localparam logic [pPOS_WIDTH-1:0]  POS_ONE      = pPOS_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    ps_dir_e                dir_q;
    logic [pSTEP_WIDTH-1:0] remaining_q;
    logic [pPOS_WIDTH-1:0]  position_q;
    logic [CNT_W-1:0]       tcnt_q;
    logic                   done_q, error_q, timeout_q, abort_pend_q;

    logic [pSTEP_WIDTH-1:0] mag;
    logic                   done_d, set_error, set_timeout, step_done;

    // Most-negative input negates to 2^(W-1), which is representable unsigned.
    assign mag       = I_steps[pSTEP_WIDTH-1] ? (~I_steps + STEP_ONE) : I_steps;
    assign step_done = (state_q == ST_WAIT) && I_psdone;

    // MMCM protocol: psen is a one-cycle request; the shift is complete when
    // psdone pulses. Only one request is outstanding at any time, and a
    // psdone is honoured only while waiting for it.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        set_error   = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    if (mag == '0) begin
                        done_d = 1'b1;
                    end else if (!I_locked) begin
                        set_error = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_PULSE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (I_psdone) begin
                    if (remaining_q == STEP_ONE || abort_pend_q || I_abort || !I_locked) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        set_error = !I_locked;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    set_error   = 1'b1;
                    set_timeout = 1'b1;
                end
            end
            ST_SETTLE: state_d = ST_PULSE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            dir_q        <= PS_DEC;
            remaining_q  <= '0;
            position_q   <= '0;
            tcnt_q       <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (state_q == ST_IDLE && I_start) begin
                dir_q        <= I_steps[pSTEP_WIDTH-1] ? PS_DEC : PS_INC;
                remaining_q  <= mag;
                error_q      <= set_error;
                timeout_q    <= 1'b0;
                abort_pend_q <= 1'b0;
            end else begin
                if (set_error)   error_q   <= 1'b1;
                if (set_timeout) timeout_q <= 1'b1;
                if (state_q != ST_IDLE && I_abort) abort_pend_q <= 1'b1;
            end

            if (state_q == ST_PULSE)     tcnt_q <= '0;
            else if (state_q == ST_WAIT) tcnt_q <= tcnt_q + CNT_W'(1);

            if (step_done) begin
                remaining_q <= remaining_q - STEP_ONE;
                position_q  <= (dir_q == PS_INC) ? position_q + POS_ONE : position_q - POS_ONE;
            end
            // Clearing takes priority over a step landing in the same cycle.
            if (I_clear_pos) position_q <= '0;
        end
    end

    assign O_psen      = (state_q == ST_PULSE);
    assign O_busy      = (state_q != ST_IDLE);
    assign O_psincdec  = (dir_q == PS_INC);
    assign O_done      = done_q;
    assign O_error     = error_q;
    assign O_timeout   = timeout_q;
    assign O_remaining = remaining_q;
    assign O_position  = position_q;

endmodule

// File: tb/tb_trig_clk_ps_seq.sv
// Bench for trig_clk_ps_seq: directed scenarios plus randomized commands,
// checked against step-count arithmetic kept in the bench.
module tb_trig_clk_ps_seq;

    localparam int TMO = 40;

    logic        cwusb_clk;
    logic        reset_i;
    logic        I_start, I_abort, I_clear_pos, I_locked, I_psdone;
    logic [15:0] I_steps;
    logic        O_psen, O_psincdec, O_busy, O_done, O_error, O_timeout;
    logic [15:0] O_remaining, O_position;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_pos = '0;

    trig_clk_ps_seq #(
        .pSTEP_WIDTH(16),
        .pPOS_WIDTH(16),
        .pTIMEOUT_CYCLES(TMO)
    ) dut (
        .cwusb_clk(cwusb_clk),
        .reset_i(reset_i),
        .I_start(I_start),
        .I_steps(I_steps),
        .I_abort(I_abort),
        .I_clear_pos(I_clear_pos),
        .I_locked(I_locked),
        .I_psdone(I_psdone),
        .O_psen(O_psen),
        .O_psincdec(O_psincdec),
        .O_busy(O_busy),
        .O_done(O_done),
        .O_error(O_error),
        .O_timeout(O_timeout),
        .O_remaining(O_remaining),
        .O_position(O_position)
    );

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    task automatic tick();
        @(posedge cwusb_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psen"}, O_psen, 0);
        check({tag, "_dir"}, O_psincdec, 0);
        check({tag, "_busy"}, O_busy, 0);
        check({tag, "_done"}, O_done, 0);
        check({tag, "_err"}, O_error, 0);
        check({tag, "_tmo"}, O_timeout, 0);
        check({tag, "_rem"}, O_remaining, 0);
        check({tag, "_pos"}, O_position, 0);
    endtask

    // One command acting as the MMCM. The *_at arguments name the 1-based step
    // on which an event is injected (0 = never). Expected results come from
    // step counts: completed steps move the position, the rest stay remaining.
    task automatic run_cmd(input logic [15:0] steps, input int d_fixed, input int abort_at,
                           input int drop_at, input int clear_at, input int unlock_at,
                           input int restart_at);
        int s, mag, d, prev_cyc, prev_d;
        bit inc, last;
        s   = int'($signed(steps));
        mag = (s < 0) ? -s : s;
        inc = (s >= 0);
        I_steps = steps;
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        if (mag == 0) begin
            check("zero_done", O_done, 1);
            check("zero_psen", O_psen, 0);
            check("zero_err", O_error, 0);
            check("zero_rem", O_remaining, 0);
            tick();
            check("zero_done_once", O_done, 0);
            return;
        end
        if (!I_locked) begin
            check("lock_psen", O_psen, 0);
            check("lock_done", O_done, 1);
            check("lock_err", O_error, 1);
            check("lock_rem", O_remaining, mag);
            check("lock_busy", O_busy, 0);
            tick();
            check("lock_psen_later", O_psen, 0);
            return;
        end
        check("start_err", O_error, 0);
        check("start_tmo", O_timeout, 0);
        prev_cyc = 0;
        prev_d   = 0;
        for (int k = 1; k <= mag; k++) begin
            check("psen", O_psen, 1);
            check("busy", O_busy, 1);
            check("dir", O_psincdec, inc);
            if (k > 1) check("spacing", cyc - prev_cyc, prev_d + 2);
            prev_cyc = cyc;
            d = (k == drop_at) ? TMO : ((d_fixed > 0) ? d_fixed : int'($urandom_range(1, TMO)));
            for (int t = 1; t <= d; t++) begin
                tick();
                if (t == 1) begin
                    if (k == abort_at) I_abort = 1'b1;
                    if (k == restart_at) begin
                        I_start = 1'b1;
                        I_steps = 16'd7;
                    end
                end else begin
                    I_abort = 1'b0;
                    I_start = 1'b0;
                end
                if (t > 1 && t < d) check("wait_psen", O_psen, 0);
            end
            if (k == drop_at) begin
                I_abort = 1'b0;
                I_start = 1'b0;
                check("tmo_still_busy", O_busy, 1);
                tick();
                check("tmo_done", O_done, 1);
                check("tmo_busy", O_busy, 0);
                check("tmo_err", O_error, 1);
                check("tmo_flag", O_timeout, 1);
                check("tmo_rem", O_remaining, mag - k + 1);
                check("tmo_pos", O_position, exp_pos);
                tick();
                check("tmo_done_once", O_done, 0);
                break;
            end
            I_psdone = 1'b1;
            if (k == clear_at) I_clear_pos = 1'b1;
            if (k == unlock_at) I_locked = 1'b0;
            tick();
            I_psdone    = 1'b0;
            I_clear_pos = 1'b0;
            I_abort     = 1'b0;
            I_start     = 1'b0;
            I_locked    = 1'b1;
            if (k == clear_at) exp_pos = '0;
            else exp_pos = inc ? exp_pos + 16'd1 : exp_pos - 16'd1;
            check("pos", O_position, exp_pos);
            check("rem", O_remaining, mag - k);
            last = (k == mag) || (k == abort_at) || (k == unlock_at);
            if (last) begin
                check("end_done", O_done, 1);
                check("end_busy", O_busy, 0);
                check("end_err", O_error, (k == unlock_at));
                check("end_tmo", O_timeout, 0);
                tick();
                check("end_done_once", O_done, 0);
                check("end_psen", O_psen, 0);
                break;
            end
            check("settle_done", O_done, 0);
            check("settle_busy", O_busy, 1);
            check("settle_psen", O_psen, 0);
            tick();
            prev_d = d;
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        I_start     = 1'b0;
        I_steps     = '0;
        I_abort     = 1'b0;
        I_clear_pos = 1'b0;
        I_locked    = 1'b1;
        I_psdone    = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_i = 1'b0;
        tick();

        // +3 with fixed 12-cycle psdone latency: 14-cycle psen spacing
        run_cmd(16'd3, 12, 0, 0, 0, 0, 0);
        check("plus3_pos", O_position, 16'd3);

        I_clear_pos = 1'b1;
        tick();
        I_clear_pos = 1'b0;
        exp_pos = '0;
        check("clear_idle", O_position, 0);

        run_cmd(16'hFFFE, 0, 0, 0, 0, 0, 0);
        check("minus2_pos", O_position, 16'hFFFE);

        // Most-negative request loaded without running the sequence
        I_locked = 1'b0;
        run_cmd(16'h8000, 0, 0, 0, 0, 0, 0);
        I_locked = 1'b1;
        check("most_neg_rem", O_remaining, 16'h8000);

        run_cmd(16'd0, 0, 0, 0, 0, 0, 0);

        I_clear_pos = 1'b1;
        tick();
        I_clear_pos = 1'b0;
        exp_pos = '0;
        run_cmd(16'd5, 0, 2, 0, 0, 0, 0);
        check("abort_pos", O_position, 16'd2);
        check("abort_rem", O_remaining, 16'd3);

        run_cmd(16'd1, 0, 0, 1, 0, 0, 0);
        run_cmd(16'd1, 0, 0, 0, 0, 0, 0);

        run_cmd(16'd3, 0, 0, 0, 2, 0, 0);

        // Abort and psdone while idle are both ignored
        I_abort  = 1'b1;
        I_psdone = 1'b1;
        tick();
        I_abort  = 1'b0;
        I_psdone = 1'b0;
        tick();
        check("idle_psdone_pos", O_position, exp_pos);
        check("idle_busy", O_busy, 0);
        run_cmd(16'd2, 0, 0, 0, 0, 0, 1);
        run_cmd(16'd4, 0, 0, 0, 0, 2, 0);

        // Reset in the middle of a wait
        I_steps = 16'd4;
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        check("rst_seq_psen", O_psen, 1);
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_all_zero("rst_mid");
        exp_pos  = '0;
        I_psdone = 1'b1;
        tick();
        I_psdone = 1'b0;
        check("late_psdone_pos", O_position, 0);
        check("late_psdone_busy", O_busy, 0);
        check("late_psdone_psen", O_psen, 0);

        for (int i = 0; i < 10; i++) begin
            int rs;
            rs = int'($urandom_range(0, 12)) - 6;
            run_cmd(16'(rs), 0, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 4) == 0) ? 2 : 0,
                    int'($urandom_range(0, 2)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
